ysyx_22041211_seq: RTL and testbench
====================================

YSYX_22041211_SEQ -- requirements
Module: ysyx_22041211_seq

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, width of the retired-instruction counter.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, maximum wait cycles in FETCH or MEM.
REQ-003 SHALL have port clk, input, 1, the single clock for all state.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ifu_valid, input, 1, fetched instruction available.
REQ-006 SHALL have port memory_inst_i, input, 1, current instruction is a load or store.
REQ-007 SHALL have port lsu_valid, input, 1, memory access complete.
REQ-008 SHALL have port wd_i, input, 1, decoded instruction writes a GPR.
REQ-009 SHALL have port ifu_req, output, 1, fetch request.
REQ-010 SHALL have port lsu_req, output, 1, memory access request.
REQ-011 SHALL have port rf_we_o, output, 1, GPR write strobe.
REQ-012 SHALL have port pc_we_o, output, 1, PC update strobe.
REQ-013 SHALL have port finish, output, 1, instruction retired this cycle.
REQ-014 SHALL have port inst_cnt, output, DATA_LEN, retired-instruction count.
REQ-015 SHALL have port timeout_o, output, 1, sticky watchdog error flag.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, FETCH, EXEC, MEM, WB and HALT, encoded in 3 bits.
REQ-017 SHALL make the following transitions:
- IDLE -> FETCH unconditionally.
- FETCH -> EXEC when ifu_valid = 1; otherwise stay in FETCH.
- EXEC -> MEM when memory_inst_i = 1; EXEC -> WB otherwise.
- MEM -> WB when lsu_valid = 1; otherwise stay in MEM.
- WB -> FETCH unconditionally.
REQ-018 SHALL decode outputs from the current state only:
- ifu_req = 1 only in FETCH.
- lsu_req = 1 only in MEM.
- pc_we_o = 1 and finish = 1 only in WB.
- rf_we_o = wd_i in WB, 0 in all other states.
REQ-019 SHALL sample memory_inst_i in EXEC only, and SHALL sample ifu_valid in FETCH only.
REQ-020 SHALL ignore lsu_valid outside MEM; an lsu_valid in the first MEM cycle SHALL give WB on the next cycle.
REQ-021 SHALL have a minimum latency, ifu_valid to finish, of 2 cycles for non-memory instructions and 3 cycles for memory instructions, plus any lsu_valid wait.
REQ-022 SHALL increment inst_cnt by 1 on each clock edge leaving WB, wrapping from 2^DATA_LEN-1 to 0.
REQ-023 SHALL use HALT as a terminal state: all request and strobe outputs are 0 and the FSM leaves HALT only by reset.

Reset
REQ-024 SHALL, on rst = 0, immediately force state IDLE, inst_cnt = 0, timeout_o = 0 and the wait counter to 0, regardless of the current state.
REQ-025 SHALL hold all outputs at 0 while rst = 0, and SHALL enter FETCH on the first clock edge after rst returns to 1.

Configuration
REQ-026 SHALL provide macro YSYX_22041211_SEQ_TIMEOUT_EN to compile the watchdog in or out.
REQ-027 With the macro defined, SHALL behave as follows:
- A wait counter clears on entry to FETCH or MEM and increments each cycle spent there.
- When the counter reaches TIMEOUT_CYC-1 without ifu_valid or lsu_valid respectively, timeout_o is set to 1 and the next state is HALT.
REQ-028 With the macro undefined, SHALL contain no wait counter, SHALL tie timeout_o to 0, and HALT SHALL be unreachable; all other behaviour SHALL be identical.

Structure
REQ-029 SHALL take the state encodings and the default TIMEOUT_CYC constant from the shared ysyx_22041211_define include, so that the write-back and debug logic can decode the state.
REQ-030 SHALL implement the optional watchdog as sub-module ysyx_22041211_seq_wdog (counter, compare, sticky flag), instantiated only under the macro.

Verification
REQ-031 SHALL cover:
- Non-memory instruction: ifu_valid = 1 on the first FETCH cycle with wd_i = 1 -> finish and rf_we_o pulse 2 cycles later, and inst_cnt goes 0 -> 1.
- Load: memory_inst_i = 1 with lsu_valid delayed 5 cycles -> lsu_req high for 6 cycles, finish one cycle after lsu_valid, and rf_we_o follows wd_i.
- Spurious handshakes: lsu_valid pulsed in FETCH and EXEC -> no state change, and lsu_req stays 0.
- Reset mid-MEM: rst driven low asynchronously between clock edges -> outputs 0 immediately and inst_cnt = 0; FETCH follows 1 cycle after release.
- Counter wrap: DATA_LEN = 4 with 16 instructions retired -> inst_cnt returns to 0.
- Watchdog (macro defined, TIMEOUT_CYC = 8): ifu_valid held at 0 -> timeout_o = 1 after 8 FETCH cycles, FSM stays in HALT, and ifu_req = 0; with the macro undefined, the same stimulus waits indefinitely and timeout_o stays 0.

Source files
------------

// File: rtl/ysyx_22041211_seq_pkg.sv
// Shared sequencer definitions: state encodings and default watchdog limit,
// visible to write-back and debug logic that decodes the sequencer state.
package ysyx_22041211_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_HALT  = 3'd5
  } seq_state_e;

  localparam int unsigned SEQ_TIMEOUT_CYC_DEF = 1024;

  // States in which the sequencer waits on an external handshake.
  function automatic logic is_wait_state(input seq_state_e s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/ysyx_22041211_seq_wdog.sv
// Handshake watchdog: counts cycles spent in a wait state, flags expiry on the
// last allowed cycle and keeps a sticky timeout flag until reset.
module ysyx_22041211_seq_wdog #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active_i,
  input  logic hit_i,
  output logic expire_o,
  output logic timeout_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  // Leaving the wait state clears the count, so every entry starts at zero.
  always_comb begin
    expire_o  = active_i && !hit_i && (cnt_q == CNT_LAST);
    cnt_d     = active_i ? cnt_q + 1'b1 : '0;
    timeout_d = timeout_q | expire_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/ysyx_22041211_seq.sv
// Multi-cycle instruction sequencer (IDLE/FETCH/EXEC/MEM/WB/HALT).
// Define YSYX_22041211_SEQ_TIMEOUT_EN to build in the handshake watchdog.
module ysyx_22041211_seq
  import ysyx_22041211_seq_pkg::*;
#(
  parameter int unsigned DATA_LEN    = 32,
  parameter int unsigned TIMEOUT_CYC = SEQ_TIMEOUT_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_valid,
  input  logic                memory_inst_i,
  input  logic                lsu_valid,
  input  logic                wd_i,
  output logic                ifu_req,
  output logic                lsu_req,
  output logic                rf_we_o,
  output logic                pc_we_o,
  output logic                finish,
  output logic [DATA_LEN-1:0] inst_cnt,
  output logic                timeout_o
);

  seq_state_e          state_q, state_d;
  logic                ifu_req_q, ifu_req_d;
  logic                lsu_req_q, lsu_req_d;
  logic                wb_q, wb_d;
  logic [DATA_LEN-1:0] inst_cnt_q, inst_cnt_d;
  logic                hit;
  logic                expire;

  assign hit = ((state_q == ST_FETCH) && ifu_valid) ||
               ((state_q == ST_MEM)   && lsu_valid);

`ifdef YSYX_22041211_SEQ_TIMEOUT_EN
  ysyx_22041211_seq_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk       (clk),
    .rst_n     (rst),
    .active_i  (is_wait_state(state_q)),
    .hit_i     (hit),
    .expire_o  (expire),
    .timeout_o (timeout_o)
  );
`else
  // Without the watchdog the limit has no meaning; keep it referenced.
  logic unused_wdog;
  assign unused_wdog = hit ^ (TIMEOUT_CYC == 0);
  assign expire      = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (ifu_valid)   state_d = ST_EXEC;
        else if (expire) state_d = ST_HALT;
      end
      ST_EXEC:  state_d = memory_inst_i ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (lsu_valid)   state_d = ST_WB;
        else if (expire) state_d = ST_HALT;
      end
      ST_WB:    state_d = ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state, so they track state_q exactly.
    ifu_req_d  = (state_d == ST_FETCH);
    lsu_req_d  = (state_d == ST_MEM);
    wb_d       = (state_d == ST_WB);
    inst_cnt_d = inst_cnt_q + {{(DATA_LEN-1){1'b0}}, (state_q == ST_WB)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ifu_req_q  <= 1'b0;
      lsu_req_q  <= 1'b0;
      wb_q       <= 1'b0;
      inst_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ifu_req_q  <= ifu_req_d;
      lsu_req_q  <= lsu_req_d;
      wb_q       <= wb_d;
      inst_cnt_q <= inst_cnt_d;
    end
  end

  assign ifu_req  = ifu_req_q;
  assign lsu_req  = lsu_req_q;
  assign pc_we_o  = wb_q;
  assign finish   = wb_q;
  assign rf_we_o  = wb_q & wd_i;
  assign inst_cnt = inst_cnt_q;

endmodule

// File: tb/tb_ysyx_22041211_seq.sv
// Directed self-checking bench for ysyx_22041211_seq (DATA_LEN=4, TIMEOUT_CYC=8).
// Expectations for the stalled fetch depend on YSYX_22041211_SEQ_TIMEOUT_EN.
module tb_ysyx_22041211_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       ifu_valid, memory_inst_i, lsu_valid, wd_i;
  logic       ifu_req, lsu_req, rf_we_o, pc_we_o, finish, timeout_o;
  logic [3:0] inst_cnt;

  int checks = 0;
  int passes = 0;

  ysyx_22041211_seq #(
    .DATA_LEN    (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_valid     (ifu_valid),
    .memory_inst_i (memory_inst_i),
    .lsu_valid     (lsu_valid),
    .wd_i          (wd_i),
    .ifu_req       (ifu_req),
    .lsu_req       (lsu_req),
    .rf_we_o       (rf_we_o),
    .pc_we_o       (pc_we_o),
    .finish        (finish),
    .inst_cnt      (inst_cnt),
    .timeout_o     (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Expected vector order: {ifu_req, lsu_req, rf_we_o, pc_we_o, finish}
  task automatic chk_out(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, ifu_req, lsu_req, rf_we_o, pc_we_o, finish}, {27'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_cnt;

  initial begin
    rst = 1'b0; ifu_valid = 1'b0; memory_inst_i = 1'b0; lsu_valid = 1'b0; wd_i = 1'b0;
    #3;
    chk_out("reset_outs", 5'b00000);
    check("reset_cnt", inst_cnt, 0);
    check("reset_timeout", timeout_o, 0);
    step(); step();
    rst = 1'b1;
    chk_out("idle_outs", 5'b00000);
    step();
    chk_out("first_fetch", 5'b10000);

    // Non-memory instruction with GPR write
    ifu_valid = 1'b1; wd_i = 1'b1;
    step();
    ifu_valid = 1'b0;
    chk_out("alu_exec", 5'b00000);
    step();
    chk_out("alu_wb", 5'b00111);
    check("alu_cnt_wb", inst_cnt, 0);
    step();
    chk_out("alu_fetch", 5'b10000);
    check("alu_cnt", inst_cnt, 1);

    // Load with lsu_valid arriving in the sixth MEM cycle
    ifu_valid = 1'b1; memory_inst_i = 1'b1;
    step();
    ifu_valid = 1'b0;
    chk_out("ld_exec", 5'b00000);
    step();
    for (int i = 0; i < 6; i++) begin
      chk_out($sformatf("ld_mem%0d", i), 5'b01000);
      if (i == 5) lsu_valid = 1'b1;
      step();
    end
    lsu_valid = 1'b0; memory_inst_i = 1'b0;
    chk_out("ld_wb", 5'b00111);
    step();
    chk_out("ld_fetch", 5'b10000);
    check("ld_cnt", inst_cnt, 2);

    // Spurious lsu_valid in FETCH/EXEC; memory_inst_i only counts in EXEC
    lsu_valid = 1'b1; memory_inst_i = 1'b1;
    step();
    chk_out("spur_fetch_hold", 5'b10000);
    ifu_valid = 1'b1; wd_i = 1'b0;
    step();
    ifu_valid = 1'b0; memory_inst_i = 1'b0;
    chk_out("spur_exec", 5'b00000);
    step();
    chk_out("spur_wb_nowd", 5'b00011);
    wd_i = 1'b1;
    #1;
    check("spur_wb_wd", rf_we_o, 1);
    wd_i = 1'b0;
    step();
    lsu_valid = 1'b0;
    chk_out("spur_fetch", 5'b10000);
    check("spur_cnt", inst_cnt, 3);

    // Asynchronous reset in the middle of a MEM cycle
    ifu_valid = 1'b1; memory_inst_i = 1'b1;
    step();
    ifu_valid = 1'b0;
    step();
    chk_out("rmem_mem", 5'b01000);
    #3 rst = 1'b0;
    #1;
    chk_out("rmem_outs", 5'b00000);
    check("rmem_cnt", inst_cnt, 0);
    step();
    chk_out("rmem_held", 5'b00000);
    rst = 1'b1; memory_inst_i = 1'b0;
    step();
    chk_out("rmem_fetch", 5'b10000);

    // Counter wrap after 16 retirements
    exp_cnt = 4'd0;
    for (int i = 0; i < 16; i++) begin
      ifu_valid = 1'b1;
      step();
      ifu_valid = 1'b0;
      step();
      step();
      exp_cnt = exp_cnt + 4'd1;
      check($sformatf("wrap_cnt%0d", i), inst_cnt, exp_cnt);
    end
    check("wrap_zero", inst_cnt, 0);

    // Stalled fetch: fresh FETCH entry, ifu_valid never arrives
    repeat (7) step();
    check("wd_pre_timeout", timeout_o, 0);
    chk_out("wd_pre_outs", 5'b10000);
    step();
`ifdef YSYX_22041211_SEQ_TIMEOUT_EN
    check("wd_timeout", timeout_o, 1);
    chk_out("wd_halt", 5'b00000);
    ifu_valid = 1'b1; lsu_valid = 1'b1;
    repeat (4) step();
    chk_out("wd_halt_stay", 5'b00000);
    check("wd_timeout_sticky", timeout_o, 1);
`else
    check("wd_timeout", timeout_o, 0);
    chk_out("wd_waiting", 5'b10000);
    repeat (20) step();
    chk_out("wd_still_waiting", 5'b10000);
    check("wd_timeout_stay", timeout_o, 0);
    ifu_valid = 1'b1; lsu_valid = 1'b1;
    step();
`endif
    ifu_valid = 1'b0; lsu_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("wd_reset_clear", timeout_o, 0);
    step();
    rst = 1'b1;
    step();
    chk_out("wd_restart", 5'b10000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
